// File: rtl/upio_in_cond_if.sv
// APB slave window used to configure the input-conditioning stage.
// 12-bit byte address, 32-bit data, zero wait states.
interface upio_in_cond_if;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR,
    output PWDATA,
    output PWRITE,
    output PSEL,
    output PENABLE,
    input  PRDATA,
    input  PREADY,
    input  PSLVERR
  );

  modport slave (
    input  PADDR,
    input  PWDATA,
    input  PWRITE,
    input  PSEL,
    input  PENABLE,
    output PRDATA,
    output PREADY,
    output PSLVERR
  );
endinterface

// File: rtl/upio_in_cond.sv
// Input-conditioning stage ahead of the plugin upio_in_i bus.
// Each pad bit is synchronised, optionally debounced by its own counter, and
// filtered edges are latched into PEND to raise a level interrupt.
module upio_in_cond #(
  parameter int unsigned     N_PINS   = 8,
  parameter int unsigned     DB_W     = 16,
  parameter logic [DB_W-1:0] DB_RESET = DB_W'(99)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  upio_in_cond_if.slave     bus,
  input  logic [N_PINS-1:0] pad_in_i,
  output logic [N_PINS-1:0] upio_in_o,
  output logic              int_o
);

  // Word offsets (PADDR[11:2]).
  localparam logic [9:0] AddrCtrl   = 10'd0;
  localparam logic [9:0] AddrThresh = 10'd1;
  localparam logic [9:0] AddrRise   = 10'd2;
  localparam logic [9:0] AddrFall   = 10'd3;
  localparam logic [9:0] AddrPend   = 10'd4;
  localparam logic [9:0] AddrSync   = 10'd5;
  localparam logic [9:0] AddrFilt   = 10'd6;

  localparam logic [DB_W-1:0] CntMax = '1;

  // State
  logic [N_PINS-1:0] sync1_q, sync1_d;
  logic [N_PINS-1:0] sync_q,  sync_d;
  logic [N_PINS-1:0] filt_q,  filt_d;
  logic [DB_W-1:0]   cnt_q [N_PINS];
  logic [DB_W-1:0]   cnt_d [N_PINS];
  logic [N_PINS-1:0] ctrl_q,  ctrl_d;
  logic [DB_W-1:0]   thresh_q, thresh_d;
  logic [N_PINS-1:0] rise_q,  rise_d;
  logic [N_PINS-1:0] fall_q,  fall_d;
  logic [N_PINS-1:0] pend_q,  pend_d;
  logic              int_q,   int_d;

  // Bus decode
  logic [9:0]        word;
  logic              mapped;
  logic              access;
  logic              wr_en;
  logic [N_PINS-1:0] wdata_pins;
  logic [N_PINS-1:0] w1c;
  logic [N_PINS-1:0] rise_ev;
  logic [N_PINS-1:0] fall_ev;

  // Address bits below word granularity and upper data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus.PADDR[1:0], bus.PWDATA};

  assign word       = bus.PADDR[11:2];
  assign mapped     = (word <= AddrFilt);
  assign access     = bus.PSEL & bus.PENABLE;
  assign wr_en      = access & bus.PWRITE & mapped;
  assign wdata_pins = bus.PWDATA[N_PINS-1:0];

  assign bus.PREADY  = 1'b1;
  assign bus.PSLVERR = access & ~mapped;

  // Combinational read mux, qualified by PSEL only so data is valid in setup phase too.
  always_comb begin
    bus.PRDATA = '0;
    if (bus.PSEL) begin
      unique case (word)
        AddrCtrl:   bus.PRDATA = 32'(ctrl_q);
        AddrThresh: bus.PRDATA = 32'(thresh_q);
        AddrRise:   bus.PRDATA = 32'(rise_q);
        AddrFall:   bus.PRDATA = 32'(fall_q);
        AddrPend:   bus.PRDATA = 32'(pend_q);
        AddrSync:   bus.PRDATA = 32'(sync_q);
        AddrFilt:   bus.PRDATA = 32'(filt_q);
        default:    bus.PRDATA = '0;
      endcase
    end
  end

  // Configuration register writes.
  always_comb begin
    ctrl_d   = ctrl_q;
    thresh_d = thresh_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    if (wr_en) begin
      unique case (word)
        AddrCtrl:   ctrl_d   = wdata_pins;
        AddrThresh: thresh_d = bus.PWDATA[DB_W-1:0];
        AddrRise:   rise_d   = wdata_pins;
        AddrFall:   fall_d   = wdata_pins;
        default:    ;
      endcase
    end
  end

  // Synchroniser and per-bit debounce filter.
  always_comb begin
    sync1_d = pad_in_i;
    sync_d  = sync1_q;
    filt_d  = filt_q;
    for (int i = 0; i < int'(N_PINS); i++) begin
      cnt_d[i] = '0;
      if (!ctrl_q[i]) begin
        filt_d[i] = sync_q[i];
      end else if (sync_q[i] != filt_q[i]) begin
        // >= so that lowering THRESH mid-count releases on the next edge.
        if (cnt_q[i] >= thresh_q) begin
          filt_d[i] = sync_q[i];
        end else if (cnt_q[i] != CntMax) begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
  end

  // Edge latch: a new event in the same cycle as a W1C on that bit keeps it set.
  always_comb begin
    rise_ev = filt_d & ~filt_q;
    fall_ev = ~filt_d & filt_q;
    w1c     = (wr_en && word == AddrPend) ? wdata_pins : '0;
    pend_d  = (pend_q & ~w1c) | (rise_ev & rise_q) | (fall_ev & fall_q);
    int_d   = |pend_d;
  end

  // State registers; THRESH is the only field with a non-zero reset value.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync_q   <= '0;
      filt_q   <= '0;
      ctrl_q   <= '0;
      thresh_q <= DB_RESET;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      int_q    <= 1'b0;
      for (int i = 0; i < int'(N_PINS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      ctrl_q   <= ctrl_d;
      thresh_q <= thresh_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
      int_q    <= int_d;
      for (int i = 0; i < int'(N_PINS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign upio_in_o = filt_q;
  assign int_o     = int_q;

endmodule

// File: tb/tb_upio_in_cond.sv
// Bench for upio_in_cond: directed scenarios plus random pad/APB traffic, all
// checked against a run-length behavioural model of the conditioning stage.
module tb_upio_in_cond;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] pad = 8'h00;
  logic [7:0] upio;
  logic       intr;
  int         total = 0;
  int         bad = 0;

  upio_in_cond_if bus();

  upio_in_cond dut (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .pad_in_i  (pad),
    .upio_in_o (upio),
    .int_o     (intr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // pad is seen two edges later; a debounced bit flips once it has disagreed with
  // the filtered value for THRESH+1 consecutive edges.
  logic [7:0]  m_s1, m_s2, m_filt, m_ctrl, m_rise, m_fall, m_pend;
  logic [15:0] m_thr;
  logic        m_int;
  int          m_run [8];

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] nf, np, w1c;
    int         nrun [8];
    logic       acc;
    if (!rst_n) begin
      m_s1 <= 0; m_s2 <= 0; m_filt <= 0; m_ctrl <= 0; m_rise <= 0; m_fall <= 0;
      m_pend <= 0; m_int <= 0; m_thr <= 16'd99;
      for (int i = 0; i < 8; i++) m_run[i] <= 0;
    end else begin
      nf = m_filt;
      for (int i = 0; i < 8; i++) begin
        nrun[i] = 0;
        if (!m_ctrl[i]) nf[i] = m_s2[i];
        else if (m_s2[i] != m_filt[i]) begin
          nrun[i] = m_run[i] + 1;
          if (nrun[i] > int'(m_thr)) begin
            nf[i] = m_s2[i];
            nrun[i] = 0;
          end
        end
      end
      acc = bus.PSEL & bus.PENABLE & bus.PWRITE;
      w1c = (acc && bus.PADDR[11:2] == 10'd4) ? bus.PWDATA[7:0] : 8'h00;
      np  = (m_pend & ~w1c) | (nf & ~m_filt & m_rise) | (~nf & m_filt & m_fall);
      m_pend <= np;
      m_int  <= |np;
      m_filt <= nf;
      for (int i = 0; i < 8; i++) m_run[i] <= nrun[i];
      if (acc) begin
        case (bus.PADDR[11:2])
          10'd0: m_ctrl <= bus.PWDATA[7:0];
          10'd1: m_thr  <= bus.PWDATA[15:0];
          10'd2: m_rise <= bus.PWDATA[7:0];
          10'd3: m_fall <= bus.PWDATA[7:0];
          default: ;
        endcase
      end
      m_s1 <= pad;
      m_s2 <= m_s1;
    end
  end

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a[11:2])
      10'd0: return 32'(m_ctrl);
      10'd1: return 32'(m_thr);
      10'd2: return 32'(m_rise);
      10'd3: return 32'(m_fall);
      10'd4: return 32'(m_pend);
      10'd5: return 32'(m_s2);
      10'd6: return 32'(m_filt);
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Setup-phase-only read; consumes no clock.
  task automatic peek(input logic [11:0] a, output logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    #1;
    d = bus.PRDATA;
    chk("peek_prdata", d, m_read(a));
    bus.PSEL = 1'b0;
  endtask

  // Called just after a negedge; access-phase edge is the second posedge.
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    #1;
    chk("wr_pslverr", 32'(bus.PSLVERR), 32'(a[11:2] > 10'd6));
    chk("wr_pready", 32'(bus.PREADY), 32'd1);
    @(negedge clk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    #1;
    chk("rd_setup_pslverr", 32'(bus.PSLVERR), 32'd0);
    @(negedge clk);
    bus.PENABLE = 1'b1;
    #1;
    d = bus.PRDATA;
    chk("rd_prdata", d, m_read(a));
    chk("rd_pslverr", 32'(bus.PSLVERR), 32'(a[11:2] > 10'd6));
    @(negedge clk);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int          w;
    logic [7:0]  b;
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    pad = 8'hFF;
    #1 rst_n = 1'b0;

    // 1: reset
    repeat (3) @(negedge clk);
    chk("rst_upio", 32'(upio), 32'h0);
    chk("rst_int", 32'(intr), 32'h0);
    chk("rst_prdata", bus.PRDATA, 32'h0);
    chk("rst_pslverr", 32'(bus.PSLVERR), 32'h0);
    chk("rst_pready", 32'(bus.PREADY), 32'h1);
    rst_n = 1'b1;

    // Per-cycle compare of outputs against the model.
    fork
      forever begin
        @(negedge clk);
        #2;
        chk("cyc_upio", 32'(upio), 32'(m_filt));
        chk("cyc_int", 32'(intr), 32'(m_int));
      end
    join_none

    @(negedge clk);
    peek(12'h004, d); chk("thresh_rst", d, 32'd99);
    peek(12'h000, d); chk("ctrl_rst", d, 32'd0);

    // 2: bypass latency
    pad = 8'h00;
    repeat (5) @(negedge clk);
    pad = 8'hA5;
    @(negedge clk);
    peek(12'h014, d); chk("byp_sync_1clk", d, 32'h00);
    @(negedge clk);
    peek(12'h014, d); chk("byp_sync_2clk", d, 32'hA5);
    chk("byp_upio_2clk", 32'(upio), 32'h00);
    @(negedge clk);
    chk("byp_upio_3clk", 32'(upio), 32'hA5);

    // 3: debounce with THRESH=4
    apb_wr(12'h000, 32'hFF);
    apb_wr(12'h004, 32'd4);
    pad = 8'h00;
    repeat (12) @(negedge clk);
    chk("db_settle", 32'(upio), 32'h00);
    pad = 8'h01;
    repeat (3) @(negedge clk);
    pad = 8'h00;
    repeat (12) begin
      @(negedge clk);
      chk("db_glitch", 32'(upio[0]), 32'd0);
    end
    pad = 8'h01;
    repeat (6) @(negedge clk);
    chk("db_pulse_6", 32'(upio[0]), 32'd0);
    @(negedge clk);
    chk("db_pulse_7", 32'(upio[0]), 32'd1);
    repeat (3) @(negedge clk);
    pad = 8'h00;
    repeat (12) @(negedge clk);

    // 4: edge interrupts
    pad = 8'h02;
    repeat (12) @(negedge clk);
    apb_wr(12'h008, 32'h01);
    apb_wr(12'h00C, 32'h02);
    pad = 8'h01;
    repeat (12) @(negedge clk);
    peek(12'h010, d); chk("irq_pend", d, 32'h03);
    chk("irq_int", 32'(intr), 32'd1);
    apb_wr(12'h010, 32'h01);
    peek(12'h010, d); chk("irq_w1c0", d, 32'h02);
    chk("irq_int_still", 32'(intr), 32'd1);
    apb_wr(12'h010, 32'h02);
    chk("irq_int_clr", 32'(intr), 32'd0);

    // 5: W1C colliding with a new rising edge (bypass for exact timing)
    apb_wr(12'h000, 32'h00);
    pad = 8'h00;
    repeat (6) @(negedge clk);
    pad = 8'h01;
    repeat (6) @(negedge clk);
    pad = 8'h00;
    repeat (6) @(negedge clk);
    pad = 8'h01;
    @(negedge clk);
    apb_wr(12'h010, 32'h01);
    peek(12'h010, d); chk("coll_pend", d, 32'h01);
    chk("coll_int", 32'(intr), 32'd1);

    // 6: unmapped accesses
    apb_rd(12'h01C, d); chk("err_rd_1c", d, 32'h0);
    apb_rd(12'h800, d); chk("err_rd_800", d, 32'h0);
    apb_wr(12'h01C, 32'hFFFF_FFFF);
    apb_wr(12'h800, 32'hFFFF_FFFF);
    peek(12'h000, d); chk("err_ctrl", d, 32'h00);
    peek(12'h004, d); chk("err_thresh", d, 32'd4);
    peek(12'h008, d); chk("err_rise", d, 32'h01);
    peek(12'h00C, d); chk("err_fall", d, 32'h02);
    peek(12'h010, d); chk("err_pend", d, 32'h01);
    apb_rd(12'h004, d); chk("ok_rd_thresh", d, 32'd4);

    // 7: random traffic
    for (int it = 0; it < 300; it++) begin
      if (it == 150) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          pad = pad ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
          repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        4, 5: begin
          w = int'($urandom_range(0, 4));
          d = $urandom;
          if (w == 1) d = $urandom_range(0, 6);
          apb_wr(12'(w * 4), d);
        end
        6: peek(12'($urandom_range(0, 7) * 4), d);
        7: apb_rd(12'($urandom_range(0, 4095)), d);
        8: begin
          b = 8'(1 << $urandom_range(0, 7));
          pad = pad ^ b;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          pad = pad ^ b;
          @(negedge clk);
        end
        default: repeat (10) @(negedge clk);
      endcase
    end
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
